// File: rtl/wrr_arb_pkg.sv
// ============================================================================
// Module   : wrr_arb_pkg
// Brief    : Shared FSM encoding and default sizing for the WRR bus arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package wrr_arb_pkg;

  localparam int DEF_N        = 4;
  localparam int DEF_WEIGHT_W = 3;
  localparam int DEF_TIMEOUT  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/wrr_bus_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Rotating-priority picker; first asserted request at or after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   winner_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic [IDW-1:0] w_j;

  always_comb begin
    winner_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    w_j      = '0;
    for (int i = 0; i < N; i++) begin
      w_j = IDW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[w_j]) begin
        any_o         = 1'b1;
        winner_o[w_j] = 1'b1;
        idx_o         = w_j;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wrr_bus_arbiter.sv
// ============================================================================
// Module   : wrr_bus_arbiter
// Brief    : Weighted round-robin arbiter with per-grant credit and timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wrr_bus_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1,
  localparam int TW      = $clog2(TIMEOUT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          done,
  input  logic [N*WEIGHT_W-1:0] weight_cfg,
  output logic [N-1:0]          gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  gnt_valid,
  output logic                  timeout_err
);

  state_e                state_q;
  logic [N-1:0]          gnt_q;
  logic [IDW-1:0]        gnt_id_q;
  logic                  gnt_valid_q;
  logic                  terr_q;
  logic [IDW-1:0]        ptr_q;
  logic [WEIGHT_W-1:0]   credit_q;
  logic [TW-1:0]         tcnt_q;

  logic [N-1:0]          pick_onehot;
  logic [IDW-1:0]        pick_idx;
  logic                  pick_any;

  logic [WEIGHT_W-1:0]   credit_load_d;
  logic [WEIGHT_W-1:0]   credit_dec_d;
  logic [IDW-1:0]        ptr_d;
  logic                  done_g, req_g;
  logic                  exit_d, terr_d;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    credit_load_d = weight_cfg[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    // A zero weight still allows one transaction per grant.
    if (credit_load_d == '0) credit_load_d = WEIGHT_W'(1);
    credit_dec_d = credit_q - WEIGHT_W'(1);
    ptr_d  = (gnt_id_q == IDW'(N-1)) ? '0 : gnt_id_q + IDW'(1);
    done_g = done[gnt_id_q];
    req_g  = req[gnt_id_q];
    exit_d = 1'b0;
    terr_d = 1'b0;
    if (state_q == GRANT) begin
      if (done_g) begin
        exit_d = (credit_dec_d == '0) || !req_g;
      end else if (!req_g) begin
        exit_d = 1'b1;
      end else if (tcnt_q == TW'(TIMEOUT-1)) begin
        exit_d = 1'b1;
        terr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      terr_q      <= 1'b0;
      ptr_q       <= '0;
      credit_q    <= '0;
      tcnt_q      <= '0;
    end else begin
      terr_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (pick_any) begin
            state_q     <= GRANT;
            gnt_q       <= pick_onehot;
            gnt_id_q    <= pick_idx;
            gnt_valid_q <= 1'b1;
            credit_q    <= credit_load_d;
            tcnt_q      <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (exit_d) begin
            state_q     <= GAP;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            terr_q      <= terr_d;
          end else if (done_g) begin
            credit_q <= credit_dec_d;
            tcnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_id      = gnt_id_q;
  assign gnt_valid   = gnt_valid_q;
  assign timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_wrr_bus_arbiter.sv
// ============================================================================
// Module   : tb_wrr_bus_arbiter
// Brief    : Directed self-checking bench for wrr_bus_arbiter (N=4, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wrr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  done = '0;
  logic [11:0] weight_cfg = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_valid;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  wrr_bus_arbiter #(
    .N        (4),
    .WEIGHT_W (3),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .weight_cfg  (weight_cfg),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .gnt_valid   (gnt_valid),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset state
    #1 rst = 1'b1;
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);

    // Round robin, all weights 1
    weight_cfg = 12'b001_001_001_001;
    req = 4'b1111;
    rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << order[k]));
      chk("rr_id", 32'(gnt_id), 32'(order[k]));
      chk("rr_valid", 32'(gnt_valid), 32'h1);
      done = 4'b0001 << order[k];
      step();
      done = '0;
      chk("rr_gap_gnt", 32'(gnt), 32'h0);
      chk("rr_gap_valid", 32'(gnt_valid), 32'h0);
      if (k < 4) step();
    end
    req = '0;
    step();
    chk("idle_gnt", 32'(gnt), 32'h0);

    // Weight 3, single requester, done every second cycle
    weight_cfg = 12'b001_001_001_011;
    req = 4'b0001;
    step();
    for (int t = 0; t < 3; t++) begin
      chk("w3_gnt_a", 32'(gnt), 32'h1);
      step();
      chk("w3_gnt_b", 32'(gnt), 32'h1);
      done = 4'b0001;
      step();
      done = '0;
    end
    chk("w3_gap", 32'(gnt), 32'h0);
    step();
    chk("w3_regrant", 32'(gnt), 32'h1);
    req = '0;
    step();
    chk("w3_abort_gap", 32'(gnt), 32'h0);
    step();

    // Abort by dropping req, from ptr=0
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    req = 4'b0110;
    step();
    chk("abort_gnt1", 32'(gnt), 32'h2);
    req = 4'b0100;
    step();
    chk("abort_gap", 32'(gnt), 32'h0);
    chk("abort_err", 32'(timeout_err), 32'h0);
    step();
    chk("abort_gnt2", 32'(gnt), 32'h4);
    chk("abort_err2", 32'(timeout_err), 32'h0);
    req = '0;
    step();
    step();

    // Timeout: requester 3 held, no done
    req = 4'b1000;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("to_gnt", 32'(gnt), 32'h8);
      chk("to_noerr", 32'(timeout_err), 32'h0);
      step();
    end
    chk("to_gap_gnt", 32'(gnt), 32'h0);
    chk("to_err", 32'(timeout_err), 32'h1);
    req = 4'b1001;
    step();
    chk("to_ptr0_gnt", 32'(gnt), 32'h1);
    chk("to_err_clr", 32'(timeout_err), 32'h0);
    req = '0;
    step();
    step();

    // Done in the last timeout cycle wins; stray done ignored; weight 0 acts as 1
    weight_cfg = 12'b001_001_001_000;
    req = 4'b0001;
    step();
    chk("lt_gnt", 32'(gnt), 32'h1);
    done = 4'b0100;
    step();
    done = '0;
    chk("stray_done_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 14; i++) step();
    chk("lt_gnt_late", 32'(gnt), 32'h1);
    done = 4'b0001;
    step();
    done = '0;
    chk("lt_gap_gnt", 32'(gnt), 32'h0);
    chk("lt_gap_err", 32'(timeout_err), 32'h0);
    step();
    chk("lt_regrant", 32'(gnt), 32'h1);
    chk("lt_err2", 32'(timeout_err), 32'h0);
    req = '0;
    step();
    step();

    // Async reset mid-grant
    req = 4'b0100;
    step();
    chk("ar_gnt", 32'(gnt), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt0", 32'(gnt), 32'h0);
    chk("ar_valid0", 32'(gnt_valid), 32'h0);
    chk("ar_err0", 32'(timeout_err), 32'h0);
    req = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("ar_first_gnt", 32'(gnt), 32'h1);
    chk("ar_first_id", 32'(gnt_id), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wrr_bus_arbiter.md
WRR_BUS_ARBITER -- requirements
Module: wrr_bus_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters.
REQ-002 Parameter WEIGHT_W, default 3, width of each per-requester weight field.
REQ-003 Parameter TIMEOUT, default 16, maximum cycles one grant may wait for done before forced release.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req  input  N  per-requester request level; held high while the requester wants the resource.
REQ-007 done  input  N  per-requester one-cycle pulse marking end of one transaction; honoured only for the granted requester.
REQ-008 weight_cfg  input  N*WEIGHT_W  field i is requester i's max consecutive transactions per grant; sampled when a grant is issued.
REQ-009 gnt  output  N  registered one-hot grant; all-zero when nobody is granted.
REQ-010 gnt_id  output  clog2(N)  binary index of granted requester; valid only while gnt_valid.
REQ-011 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-012 timeout_err  output  1  one-cycle pulse when a grant is force-released by timeout.

Function
REQ-013 States SHALL be IDLE (no grant), GRANT (gnt one-hot held), GAP (one-cycle turnaround, gnt all-zero).
REQ-014 Winner selection SHALL be rotating priority: first asserted req at index ptr, ptr+1, ... wrapping N-1 to 0.
REQ-015 IDLE: any req high -> GRANT to winner next cycle (req at edge t -> gnt at t+1); no req -> stay IDLE.
REQ-016 On entering GRANT, credit SHALL load weight_cfg field of winner; weight 0 SHALL be treated as 1; timeout counter SHALL clear.
REQ-017 GRANT, done[gnt_id] pulse: credit decrements; if credit after decrement >0 and req[gnt_id] high -> stay GRANT, timeout counter clears; else -> GAP.
REQ-018 GRANT, req[gnt_id] low without done -> GAP (abort); done and req low in same cycle SHALL count as done.
REQ-019 GRANT, timeout counter reaching TIMEOUT-1 with no done that cycle -> GAP and timeout_err pulse in that GAP cycle; done in the same cycle SHALL win, no error.
REQ-020 done on non-granted lines SHALL be ignored.
REQ-021 On every GRANT->GAP exit, ptr SHALL become (gnt_id+1) mod N.
REQ-022 GAP: gnt zero for exactly one cycle; then arbitrate as IDLE (any req -> GRANT, else IDLE).
REQ-023 A single requester with continuous req and weight W SHALL receive W transactions, one GAP cycle, then be re-granted if sole requester.
REQ-024 gnt, gnt_id, gnt_valid, timeout_err SHALL all be driven from registers; no combinational path from req/done to outputs.

Reset
REQ-025 rst high SHALL immediately force state IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout_err=0, ptr=0, credit=0, timeout counter=0.
REQ-026 rst asserted mid-GRANT SHALL drop the grant without timeout_err; first arbitration after release SHALL start at index 0.

Structure
REQ-027 Package wrr_arb_pkg SHALL hold the state enumeration (IDLE, GRANT, GAP) and default N, WEIGHT_W, TIMEOUT constants.
REQ-028 Rotating-priority selection SHALL be a separate combinational sub-module rr_pick (inputs req, ptr; outputs one-hot winner, index, any).
REQ-029 Timeout counter width SHALL be clog2(TIMEOUT); credit width WEIGHT_W.

Verification
REQ-030 Reset, req=4'b1111, weights all 1, done pulsed each grant -> grant order 0,1,2,3,0 with one zero-gnt GAP cycle between grants.
REQ-031 req=4'b0001 only, weight0=3, done every 2 cycles -> gnt=0001 for three transactions, then one GAP cycle, then gnt=0001 again.
REQ-032 req=4'b0110, ptr=0, grant to 1, req[1] dropped without done -> GAP, then gnt=0100, no timeout_err.
REQ-033 req=4'b1000 held, no done, TIMEOUT=16 -> gnt=1000 for 16 cycles, timeout_err high for one cycle with gnt=0, ptr=0.
REQ-034 done[gnt_id] on cycle 15 of a grant (TIMEOUT=16) -> no timeout_err; done[2] while requester 0 granted -> no state change.
REQ-035 rst pulsed while gnt=0100 -> gnt=0 asynchronously; after release with req=4'b0101 -> first grant to requester 0.
